load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage front end for the 32-bit MIPS data path. It sits between the EX/MEM pipeline register and `data_memory`.
- Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses on the `data_memory` port.
- Performs sub-word stores as a two-cycle read-modify-write, stalling the pipeline for one cycle.
- Aligns and extends load data, and flags misaligned accesses.

## Interface
Parameters:
- BIG_ENDIAN, 1, byte lane order: 1 means byte offset 0 is bits [31:24]; 0 means offset 0 is bits [7:0].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and words.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word value is in the low bits.
- stall  out  1  pipeline must hold the current request unchanged this cycle.
- load_data  out  32  registered, aligned and extended load result.
- load_valid  out  1  one-cycle pulse: load_data is valid.
- misalign  out  1  one-cycle pulse: the previous request was misaligned and was dropped.
- mem_address  out  32  word index to `data_memory`, equal to {2'b00, addr[31:2]}.
- mem_write_data  out  32  write word to `data_memory`.
- mem_read  out  1  `data_memory` read enable.
- mem_write  out  1  `data_memory` write enable.
- mem_read_data  in  32  `data_memory` read port; combinational from mem_address while mem_read=1.

## Operation
- FSM states: IDLE, RMW_WR.
- Alignment rules:
  - Word: addr[1:0] must be 0.
  - Halfword: addr[0] must be 0.
  - Byte: always aligned.
- IDLE with req_valid=0: mem_read=0, mem_write=0, stall=0.
- IDLE, aligned load:
  - mem_read=1 combinationally.
  - At the edge, load_data is set from mem_read_data: the lane is selected by addr[1:0] and BIG_ENDIAN, then sign- or zero-extended.
  - load_valid pulses the next cycle.
  - stall=0.
- IDLE, aligned word store: mem_write=1, mem_write_data=req_wdata, stall=0. `data_memory` writes at the edge.
- IDLE, aligned byte or halfword store:
  - mem_read=1, stall=1.
  - At the edge, merge_q is set to mem_read_data with the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
  - addr_q is set to the word index; the FSM moves to RMW_WR.
- RMW_WR:
  - mem_write=1, mem_address=addr_q, mem_write_data=merge_q, mem_read=0, stall=0.
  - The req_* inputs (still the held request) are ignored.
  - The FSM returns to IDLE at the next edge.
- Misaligned request in IDLE:
  - No memory access: mem_read=0, mem_write=0.
  - stall=0.
  - misalign pulses the next cycle; load_valid stays 0 and load_data holds its value.
- load_data holds its last value until the next completed load.
- mem_write_data is 0 whenever mem_write=0.
- mem_address follows the current request in IDLE, and addr_q in RMW_WR.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - load_data=0, load_valid=0, misalign=0, merge_q=0, addr_q=0.
  - stall, mem_read and mem_write are forced to 0 while rst_n is low.
- Reset asserted in RMW_WR: the pending write is abandoned and no mem_write occurs. After reset release the FSM is in IDLE.
- Load latency: request in cycle N; load_valid=1 with data in cycle N+1.
- Aligned word store: one cycle, no stall.
- Sub-word store: two cycles, read in cycle N (stall=1), write in cycle N+1 (stall=0). The next request can be accepted in cycle N+2.
- Back-to-back: a load immediately after a sub-word store reads the merged word, because the write completes at the end of N+1.
- misalign and load_valid are never high together.
- At most one of mem_read and mem_write is high in any cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release -> all outputs 0 and FSM in IDLE. Assert rst_n=0 during RMW_WR -> no mem_write pulse occurs.
- Word round-trip:
  - sw 0xDEADBEEF to addr 0x10 -> mem_write=1 with mem_address=4 and no stall.
  - Then lw from 0x10 -> load_valid next cycle, load_data=0xDEADBEEF.
- Byte store RMW (BIG_ENDIAN=1):
  - Word 4 holds 0x11223344; sb 0xAA to 0x11 -> stall high for 1 cycle, then mem_write_data=0x11AA3344.
  - Then lbu 0x11 -> 0x000000AA; lb 0x11 -> 0xFFFFFFAA.
- Halfword: sh 0x8001 to 0x12 over 0x11223344 -> word becomes 0x11228001. Then lh 0x12 -> 0xFFFF8001; lhu 0x12 -> 0x00008001.
- Misalignment: lw 0x11, sh 0x13, lh 0x01 -> misalign pulses each time, mem_read=0, mem_write=0, memory unchanged, load_valid=0.
- Little-endian (BIG_ENDIAN=0): sb 0x55 to 0x20 over 0xAABBCCDD -> word becomes 0xAABBCC55; lbu 0x23 -> 0x000000AA.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage front end: byte/half/word loads and stores onto a word memory.
// Sub-word stores run as a read-modify-write that stalls the pipe one cycle.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/write     request present / 1 = store
//   req_size            00 byte, 01 half, 1x word
//   req_unsigned        zero-extend loads when 1
//   req_addr/wdata      byte address / store data (low-aligned)
//   stall               hold the current request this cycle
//   load_data/valid     registered load result and its one-cycle pulse
//   misalign            one-cycle pulse: previous request was dropped
//   mem_*               word-indexed data_memory port
module load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] merge_q;
    logic [31:0] addr_q;

    logic        aligned;
    logic        is_sub;
    logic        idle_go;
    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;
    logic [31:0] mask;
    logic [31:0] merged;

    assign is_sub  = ~req_size[1];
    assign idle_go = (state_q == IDLE) & req_valid & aligned;

    always_comb begin
        case (req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~req_addr[0];
            default: aligned = (req_addr[1:0] == 2'b00);
        endcase
    end

    // Lane = byte position counted from bit 0 of the word.
    always_comb begin
        if (!BIG_ENDIAN)
            lane = req_addr[1:0];
        else if (req_size == 2'b00)
            lane = 2'd3 - req_addr[1:0];
        else
            lane = 2'd2 - req_addr[1:0];
    end

    assign shamt   = {lane, 3'b000};
    assign rd_byte = mem_read_data[shamt +: 8];
    assign rd_half = lane[1] ? mem_read_data[31:16]
                             : mem_read_data[15:0];

    always_comb begin
        case (req_size)
            2'b00:
                ld_ext = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
            2'b01:
                ld_ext = {{16{~req_unsigned & rd_half[15]}}, rd_half};
            default:
                ld_ext = mem_read_data;
        endcase
    end

    assign mask   = (req_size == 2'b00 ? 32'h0000_00FF
                                       : 32'h0000_FFFF) << shamt;
    assign merged = (mem_read_data & ~mask)
                  | ((req_wdata << shamt) & mask);

    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = 32'h0;
        mem_address    = {2'b00, req_addr[31:2]};
        case (state_q)
            IDLE: begin
                if (req_valid && aligned) begin
                    if (!req_write) begin
                        mem_read = 1'b1;
                    end else if (is_sub) begin
                        mem_read = 1'b1;
                        stall    = 1'b1;
                        state_d  = RMW_WR;
                    end else begin
                        mem_write      = 1'b1;
                        mem_write_data = req_wdata;
                    end
                end
            end
            RMW_WR: begin
                mem_write      = 1'b1;
                mem_address    = addr_q;
                mem_write_data = merge_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Nothing reaches memory or the pipe while reset is held.
        if (!rst_n) begin
            stall          = 1'b0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            mem_write_data = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            merge_q    <= 32'h0;
            addr_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            load_valid <= idle_go & ~req_write;
            misalign   <= (state_q == IDLE) & req_valid & ~aligned;
            if (idle_go && !req_write)
                load_data <= ld_ext;
            if (idle_go && req_write && is_sub) begin
                merge_q <= merged;
                addr_q  <= {2'b00, req_addr[31:2]};
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: big- and little-endian instances on word memories.
// Vector table plus scoreboard for load/misalign results.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        stall_b, lv_b, mis_b, mr_b, mw_b;
    logic [31:0] ld_b, ma_b, mwd_b, mrd_b;
    logic        stall_l, lv_l, mis_l, mr_l, mw_l;
    logic [31:0] ld_l, ma_l, mwd_l, mrd_l;

    logic [31:0] mem_b [0:63];
    logic [31:0] mem_l [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_a = 6'd0;
    logic [31:0] pl_d = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_b), .load_data(ld_b),
        .load_valid(lv_b), .misalign(mis_b),
        .mem_address(ma_b), .mem_write_data(mwd_b),
        .mem_read(mr_b), .mem_write(mw_b),
        .mem_read_data(mrd_b)
    );

    load_store_unit #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_l), .load_data(ld_l),
        .load_valid(lv_l), .misalign(mis_l),
        .mem_address(ma_l), .mem_write_data(mwd_l),
        .mem_read(mr_l), .mem_write(mw_l),
        .mem_read_data(mrd_l)
    );

    assign mrd_b = mr_b ? mem_b[ma_b[5:0]] : 32'h0;
    assign mrd_l = mr_l ? mem_l[ma_l[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem_b[pl_a] <= pl_d;
            mem_l[pl_a] <= pl_d;
        end else begin
            if (mw_b) mem_b[ma_b[5:0]] <= mwd_b;
            if (mw_l) mem_l[ma_l[5:0]] <= mwd_l;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          mis;
        logic [31:0] data;
    } res_t;

    res_t sb_q[$];
    res_t r_m;

    // Scoreboard: each load/misalign pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            check("lv_mis_excl", {31'b0, lv_b & mis_b}, 32'h0);
            check("rd_wr_excl", {31'b0, mr_b & mw_b}, 32'h0);
            if (lv_b || mis_b) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {30'b0, lv_b, mis_b}, 32'h0);
                end else begin
                    r_m = sb_q.pop_front();
                    check("pulse_kind", {31'b0, mis_b}, {31'b0, r_m.mis});
                    if (lv_b)
                        check("load_data", ld_b, r_m.data);
                end
            end
        end
    end

    typedef struct {
        bit          pre;
        logic [31:0] pre_w;
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          mis;
    } vec_t;

    vec_t tbl[$];

    task automatic preload(input logic [5:0] idx, input logic [31:0] w);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pl_en = 1'b1;
        pl_a = idx;
        pl_d = w;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        logic sub, e_rd, e_wr, e_st;
        res_t r;
        if (v.pre) preload(v.addr[7:2], v.pre_w);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = v.wr;
        req_size = v.sz;
        req_unsigned = v.uns;
        req_addr = v.addr;
        req_wdata = v.wd;
        if (v.mis || !v.wr) begin
            r.mis = v.mis;
            r.data = v.exp;
            sb_q.push_back(r);
        end
        sub  = ~v.sz[1];
        e_rd = !v.mis && (!v.wr || sub);
        e_wr = !v.mis && v.wr && !sub;
        e_st = !v.mis && v.wr && sub;
        @(negedge clk);
        check("mem_read", {31'b0, mr_b}, {31'b0, e_rd});
        check("mem_write", {31'b0, mw_b}, {31'b0, e_wr});
        check("stall", {31'b0, stall_b}, {31'b0, e_st});
        check("mem_address", ma_b, {2'b00, v.addr[31:2]});
        check("mem_wdata", mwd_b, e_wr ? v.wd : 32'h0);
        if (e_st) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rmw_write", {31'b0, mw_b}, 32'h1);
            check("rmw_read", {31'b0, mr_b}, 32'h0);
            check("rmw_stall", {31'b0, stall_b}, 32'h0);
            check("rmw_addr", ma_b, {2'b00, v.addr[31:2]});
            check("rmw_merge", mwd_b, v.exp);
        end
    endtask

    vec_t hv;

    initial begin
        tbl.push_back('{0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0});
        tbl.push_back('{0, 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0});
        tbl.push_back('{1, 32'h11223344, 1, 2'b00, 0, 32'h11, 32'hAA, 32'h11AA3344, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 1, 32'h11, 32'h0, 32'h000000AA, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFAA, 0});
        tbl.push_back('{1, 32'h11223344, 1, 2'b01, 0, 32'h12, 32'h8001, 32'h11228001, 0});
        tbl.push_back('{0, 0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8001, 0});
        tbl.push_back('{0, 0, 0, 2'b01, 1, 32'h12, 32'h0, 32'h00008001, 0});
        tbl.push_back('{0, 0, 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1});
        tbl.push_back('{0, 0, 1, 2'b01, 0, 32'h13, 32'h1234, 32'h0, 1});
        tbl.push_back('{0, 0, 0, 2'b01, 0, 32'h01, 32'h0, 32'h0, 1});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 32'h10, 32'h0, 32'h00000011, 0});
        tbl.push_back('{0, 0, 0, 2'b01, 1, 32'h10, 32'h0, 32'h00001122, 0});
        tbl.push_back('{0, 0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h11228001, 0});
        tbl.push_back('{0, 0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h00000001, 0});
        tbl.push_back('{0, 0, 1, 2'b00, 0, 32'h10, 32'hFFFFFF7E, 32'h7E228001, 0});
        tbl.push_back('{0, 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h7E228001, 0});
        tbl.push_back('{0, 0, 1, 2'b10, 0, 32'h12, 32'hFFFFFFFF, 32'h0, 1});

        // Reset with a load presented: nothing may reach memory.
        req_valid = 1'b1;
        req_size = 2'b10;
        req_addr = 32'h10;
        @(negedge clk);
        check("rst_mem_read", {31'b0, mr_b}, 32'h0);
        check("rst_stall", {31'b0, stall_b}, 32'h0);
        @(negedge clk);
        check("rst_load_valid", {31'b0, lv_b}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_load_data", ld_b, 32'h0);
        check("post_rst_load_valid", {31'b0, lv_b}, 32'h0);
        check("post_rst_misalign", {31'b0, mis_b}, 32'h0);
        check("post_rst_mem_write", {31'b0, mw_b}, 32'h0);
        check("post_rst_mem_read", {31'b0, mr_b}, 32'h0);

        for (int i = 0; i < tbl.size(); i++)
            issue(tbl[i]);

        // Little-endian lanes, both instances see the same requests.
        hv = '{1, 32'hAABBCCDD, 1, 2'b00, 0, 32'h20, 32'h55, 32'h55BBCCDD, 0};
        issue(hv);
        check("misaligned_sw_no_write", mem_b[4], 32'h7E228001);
        hv = '{0, 0, 0, 2'b00, 1, 32'h23, 32'h0, 32'h000000DD, 0};
        issue(hv);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("le_load_valid", {31'b0, lv_l}, 32'h1);
        check("le_lbu", ld_l, 32'h000000AA);
        check("le_word", mem_l[8], 32'hAABBCC55);
        check("be_word", mem_b[8], 32'h55BBCCDD);

        // Reset during the write half of a sub-word store.
        preload(6'd5, 32'h01020304);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b00;
        req_addr = 32'h14;
        req_wdata = 32'h77;
        @(negedge clk);
        check("rmw_rst_stall", {31'b0, stall_b}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rst_no_write", {31'b0, mw_b}, 32'h0);
        check("rmw_rst_load_data", ld_b, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rmw_rst_idle_write", {31'b0, mw_b}, 32'h0);
        check("rmw_rst_idle_stall", {31'b0, stall_b}, 32'h0);
        check("rmw_rst_mem", mem_b[5], 32'h01020304);
        hv = '{0, 0, 0, 2'b10, 0, 32'h14, 32'h0, 32'h01020304, 0};
        issue(hv);

        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
